// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD FIFO port arbiter: FSM encoding, SD block size
// and direction constants.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int SD_BLOCK_BYTES = 512;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/sd_rr_arbiter.sv
// Round-robin requester pick with a last-winner pointer; the search starts
// at the port after the pointer and wraps.
module sd_rr_arbiter
  import sd_arb_pkg::*;
#(
  parameter int N_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req,
  input  logic                       upd,
  input  logic [$clog2(N_PORTS)-1:0] upd_idx,
  output logic [N_PORTS-1:0]         pick,
  output logic [$clog2(N_PORTS)-1:0] pick_idx,
  output logic                       any_vld
);

  localparam int IDX_W = $clog2(N_PORTS);

  logic [IDX_W-1:0] ptr;
  int               cand;

  // Pointer starts on the last port so port 0 is searched first after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(N_PORTS - 1);
    end else if (upd) begin
      ptr <= upd_idx;
    end
  end

  always_comb begin
    cand     = 0;
    pick_idx = '0;
    any_vld  = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = (int'(ptr) + k) % N_PORTS;
      if (!any_vld && req[cand[IDX_W-1:0]]) begin
        any_vld  = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
    pick = any_vld ? (N_PORTS'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/sd_fifo_arbiter.sv
// N-port burst arbiter in front of the sdc_controller byte FIFO. Optional
// early-release on owner request drop is enabled with `define SD_ARB_ABORT_EN.
module sd_fifo_arbiter
  import sd_arb_pkg::*;
#(
  parameter int N_PORTS   = 2,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = SD_BLOCK_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req,
  input  logic [N_PORTS-1:0]         dir,
  input  logic [N_PORTS-1:0]         rd_en,
  output logic [N_PORTS*DATA_W-1:0]  rd_dat,
  input  logic [N_PORTS-1:0]         wr_en,
  input  logic [N_PORTS*DATA_W-1:0]  wr_dat,
  output logic [N_PORTS-1:0]         gnt,
  output logic [N_PORTS-1:0]         done,
  output logic                       busy,
`ifdef SD_ARB_ABORT_EN
  output logic                       aborted,
`endif
  output logic [$clog2(N_PORTS)-1:0] owner,
  output logic                       sd_rd_en,
  input  logic [DATA_W-1:0]          sd_rd_dat,
  output logic                       sd_wr_en,
  output logic [DATA_W-1:0]          sd_wr_dat
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  arb_state_t         state, state_nxt;
  logic [N_PORTS-1:0] gnt_nxt, done_nxt, own_oh;
  logic [IDX_W-1:0]   owner_nxt;
  logic               dir_q, dir_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               beat;
  logic               rr_upd;
  logic [N_PORTS-1:0] rr_pick;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_vld;
`ifdef SD_ARB_ABORT_EN
  logic               abort_nxt;
`endif

  sd_rr_arbiter #(
    .N_PORTS (N_PORTS)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .upd      (rr_upd),
    .upd_idx  (owner),
    .pick     (rr_pick),
    .pick_idx (rr_idx),
    .any_vld  (rr_vld)
  );

  assign own_oh = N_PORTS'(1) << owner;
  assign busy   = (state != IDLE);
  assign beat   = sd_rd_en | sd_wr_en;

  // Only the owner's strobe matching its latched direction reaches the SD side
  always_comb begin
    sd_rd_en  = 1'b0;
    sd_wr_en  = 1'b0;
    sd_wr_dat = '0;
    if (state == ACTIVE) begin
      if (dir_q == DIR_READ) begin
        sd_rd_en = rd_en[owner];
      end else begin
        sd_wr_en  = wr_en[owner];
        sd_wr_dat = wr_dat[owner*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt[p]) rd_dat[p*DATA_W +: DATA_W] = sd_rd_dat;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = '0;
    done_nxt  = '0;
    owner_nxt = owner;
    dir_nxt   = dir_q;
    cnt_nxt   = cnt_q;
    rr_upd    = 1'b0;
`ifdef SD_ARB_ABORT_EN
    abort_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rr_vld) begin
          state_nxt = ACTIVE;
          gnt_nxt   = rr_pick;
          owner_nxt = rr_idx;
          dir_nxt   = dir[rr_idx];
          cnt_nxt   = '0;
        end
      end
      ACTIVE: begin
        gnt_nxt = gnt;
        if (beat) cnt_nxt = cnt_q + CNT_W'(1);
        if (beat && (cnt_q == CNT_LAST)) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
          done_nxt  = own_oh;
          cnt_nxt   = '0;
        end
`ifdef SD_ARB_ABORT_EN
        else if (!req[owner]) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
          done_nxt  = own_oh;
          cnt_nxt   = '0;
          abort_nxt = 1'b1;
        end
`endif
      end
      RELEASE: begin
        state_nxt = IDLE;
        rr_upd    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers; reset aborts any burst without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      owner <= '0;
      dir_q <= DIR_READ;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      owner <= owner_nxt;
      dir_q <= dir_nxt;
      cnt_q <= cnt_nxt;
    end
  end

`ifdef SD_ARB_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_nxt;
    end
  end
`endif

endmodule
